// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg: shared types and widths for the memory-stage access controller.
// Revision: 1.0
package mem_pkg;
  localparam int MEM_ADDR_W       = 16;
  localparam int MEM_DATA_W       = 16;
  localparam int MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mem_state_t;
endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_wait_timer.sv
`default_nettype none
// mem_wait_timer: 8-bit saturating wait counter with a timeout compare.
// Revision: 1.0
module mem_wait_timer
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [7:0] count;
  logic [7:0] count_inc;

  assign count_inc = (count == 8'hFF) ? count : count + 8'd1;
  // Flags the cycle whose increment makes the count reach the limit.
  assign expired   = inc && (count_inc == 8'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_inc;
    end
  end
endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// mem_access_ctrl: MEM-stage req/ack controller with pipeline stall, load return and error flag.
// Revision: 1.0
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead_MEM,
  input  logic                  memWrite_MEM,
  input  logic                  halt_MEM,
  input  logic [MEM_ADDR_W-1:0] ALU_result_MEM,
  input  logic [MEM_DATA_W-1:0] st_value_MEM,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  output logic [MEM_DATA_W-1:0] readData_MEM,
  output logic                  mem_stall,
  output logic                  mem_done,
  output logic                  err
);
  mem_state_t state, state_nxt;

  logic access, start, misaligned;
  logic capture, timer_clr, timer_inc, expired, stall_c;

  assign access     = (memRead_MEM | memWrite_MEM) & ~halt_MEM;
  assign start      = access & ~ALU_result_MEM[0];
  assign misaligned = access &  ALU_result_MEM[0];

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT;
          capture   = 1'b1;
          timer_clr = 1'b1;
          stall_c   = 1'b1;
        end else if (misaligned) begin
          state_nxt = ERR;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        // An ack in the timeout cycle still completes the access.
        if (mem_ack) begin
          state_nxt = DONE;
        end else begin
          timer_inc = 1'b1;
          if (expired) state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by reset so a held request cannot stall the pipe while in reset.
  assign mem_stall = stall_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_done     <= 1'b0;
      err          <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      readData_MEM <= '0;
    end else begin
      state    <= state_nxt;
      mem_req  <= (state_nxt == WAIT);
      mem_done <= (state_nxt == DONE);
      err      <= err | (state_nxt == ERR);
      if (capture) begin
        mem_wr    <= memWrite_MEM;
        mem_addr  <= ALU_result_MEM;
        mem_wdata <= st_value_MEM;
      end
      if ((state == WAIT) && mem_ack && !mem_wr) begin
        readData_MEM <= mem_rdata;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// tb_mem_access_ctrl: transaction-level self-checking bench for mem_access_ctrl.
// Revision: 1.0
module tb_mem_access_ctrl;
  localparam int MAXW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memRead_MEM, memWrite_MEM, halt_MEM;
  logic [15:0] ALU_result_MEM, st_value_MEM;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata, readData_MEM;
  logic        mem_stall, mem_done, err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] model_rdata;
  logic        model_err;

  mem_access_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk            (clk),
    .rst            (rst),
    .memRead_MEM    (memRead_MEM),
    .memWrite_MEM   (memWrite_MEM),
    .halt_MEM       (halt_MEM),
    .ALU_result_MEM (ALU_result_MEM),
    .st_value_MEM   (st_value_MEM),
    .mem_req        (mem_req),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .readData_MEM   (readData_MEM),
    .mem_stall      (mem_stall),
    .mem_done       (mem_done),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] status();
    return {mem_req, mem_stall, mem_done, err};
  endfunction

  task automatic idle_inputs();
    memRead_MEM = 1'b0; memWrite_MEM = 1'b0; halt_MEM = 1'b0;
    ALU_result_MEM = '0; st_value_MEM = '0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic scramble_inputs();
    memRead_MEM    = 1'($urandom);
    memWrite_MEM   = 1'($urandom);
    halt_MEM       = 1'($urandom);
    ALU_result_MEM = 16'($urandom);
    st_value_MEM   = 16'($urandom);
  endtask

  // One instruction in MEM. ack_k = WAIT cycle carrying the ack (0 or >MAXW: never).
  task automatic do_access(input logic rd, input logic wr, input logic halt,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input int ack_k, input logic [15:0] rdata);
    logic is_mem, start, mis, timeout;
    int   nwait;
    is_mem = (rd | wr) & ~halt;
    start  = is_mem & ~addr[0] & ~model_err;
    mis    = is_mem &  addr[0] & ~model_err;
    memRead_MEM = rd; memWrite_MEM = wr; halt_MEM = halt;
    ALU_result_MEM = addr; st_value_MEM = wdata;
    mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
    @(negedge clk);
    check("idle_status", 64'(status()), 64'({1'b0, start, 1'b0, model_err}));
    check("idle_rdata", 64'(readData_MEM), 64'(model_rdata));
    @(posedge clk); #1;
    if (start) begin
      timeout = (ack_k < 1) || (ack_k > MAXW);
      nwait   = timeout ? MAXW : ack_k;
      for (int j = 1; j <= nwait; j++) begin
        scramble_inputs();
        mem_ack   = (j == ack_k);
        mem_rdata = (j == ack_k) ? rdata : 16'($urandom);
        @(negedge clk);
        check("wait_status", 64'(status()), 64'(4'b1100));
        check("wait_bus", 64'({mem_wr, mem_addr, mem_wdata}), 64'({wr, addr, wdata}));
        check("wait_rdata", 64'(readData_MEM), 64'(model_rdata));
        @(posedge clk); #1;
      end
      scramble_inputs();
      mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
      if (!timeout) begin
        if (!wr) model_rdata = rdata;
        @(negedge clk);
        check("done_status", 64'(status()), 64'(4'b0010));
        check("done_rdata", 64'(readData_MEM), 64'(model_rdata));
      end else begin
        model_err = 1'b1;
        @(negedge clk);
        check("timeout_status", 64'(status()), 64'(4'b0001));
      end
      @(posedge clk); #1;
    end else if (mis) begin
      model_err = 1'b1;
      @(negedge clk);
      check("misalign_status", 64'(status()), 64'(4'b0001));
      @(posedge clk); #1;
    end
  endtask

  // Asserts reset between edges with request inputs left as they are.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("reset_outputs",
          64'({mem_req, mem_stall, mem_done, err, mem_wr, readData_MEM, mem_addr, mem_wdata}), 64'(0));
    model_rdata = '0;
    model_err   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    logic rd, wr, hl;
    logic [15:0] a;
    idle_inputs();
    model_rdata = '0;
    model_err   = 1'b0;
    @(posedge clk); #1;
    do_reset();

    do_access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF);
    do_access(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234, 4, 16'h5555);
    do_access(1'b1, 1'b1, 1'b0, 16'h0022, 16'hA5A5, 2, 16'h7777);
    do_access(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, MAXW, 16'hCAFE);
    do_access(1'b0, 1'b0, 1'b0, 16'h0031, 16'h0000, 1, 16'h1111);

    for (int i = 0; i < 80; i++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      hl = ($urandom_range(0, 3) == 0);
      a  = 16'($urandom) & 16'hFFFE;
      do_access(rd, wr, hl, a, 16'($urandom), int'($urandom_range(1, MAXW)), 16'($urandom));
    end

    // Reset in the middle of a WAIT with no ack.
    memRead_MEM = 1'b1; memWrite_MEM = 1'b0; halt_MEM = 1'b0;
    ALU_result_MEM = 16'h0040; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset_req", 64'(mem_req), 64'(1));
    @(posedge clk); #1;
    do_reset();

    do_access(1'b1, 1'b0, 1'b1, 16'h0070, 16'h0000, 1, 16'h2222);
    @(negedge clk);
    check("halt_no_req", 64'(mem_req), 64'(0));
    @(posedge clk); #1;

    do_access(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000, 0, 16'h0000);
    do_access(1'b1, 1'b0, 1'b0, 16'h0060, 16'h0000, 1, 16'h3333);
    do_access(1'b0, 1'b1, 1'b0, 16'h0062, 16'h4444, 1, 16'h0000);
    do_reset();

    do_access(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 1, 16'h6666);
    do_access(1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000, 1, 16'h8888);
    @(negedge clk);
    check("err_sticky", 64'(status()), 64'(4'b0001));
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
